// File: rtl/datamover_s2mm_framer.sv
// datamover_s2mm_framer
// Cuts a continuous 32-bit sample stream into fixed bursts of BURST_WORDS
// words for the DataMover S2MM write channel. For each burst it issues one
// command (address walking a ring of NUM_SLOTS slots from BASE_ADDR), then
// passes the burst data through with tlast on the final word. The status
// stream is always accepted and used to bound the number of outstanding
// commands and to count good and bad completions.
//
// Ports:
//   clk_in1, aresetn          clock, async active-low reset
//   enable                    start new bursts while high
//   s_axis_*                  sample input stream (tdata/tvalid/tready)
//   s_axis_s2mm_cmd_*         72-bit S2MM command stream
//   s_axis_s2mm_*             S2MM data stream (tdata/tkeep/tlast/tvalid/tready)
//   m_axis_s2mm_sts_*         8-bit S2MM status stream
//   burst_count               bursts completed with OKAY status
//   err_count                 bad statuses, saturating
//   outstanding               commands issued minus statuses received
module datamover_s2mm_framer #(
    parameter int unsigned BURST_WORDS     = 128,
    parameter logic [31:0] BASE_ADDR       = 32'hC000_0000,
    parameter int unsigned NUM_SLOTS       = 16,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_in1,
    input  logic        aresetn,
    input  logic        enable,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [71:0] s_axis_s2mm_cmd_tdata,
    output logic        s_axis_s2mm_cmd_tvalid,
    input  logic        s_axis_s2mm_cmd_tready,
    output logic [31:0] s_axis_s2mm_tdata,
    output logic [3:0]  s_axis_s2mm_tkeep,
    output logic        s_axis_s2mm_tlast,
    output logic        s_axis_s2mm_tvalid,
    input  logic        s_axis_s2mm_tready,
    input  logic [7:0]  m_axis_s2mm_sts_tdata,
    input  logic        m_axis_s2mm_sts_tvalid,
    output logic        m_axis_s2mm_sts_tready,
    output logic [31:0] burst_count,
    output logic [15:0] err_count,
    output logic [3:0]  outstanding
);
    // BURST_WORDS >= 2, so CW >= 1 and word_cnt spans 0..BURST_WORDS-1.
    localparam int CW = $clog2(BURST_WORDS);
    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [CW-1:0] LAST_WORD  = CW'(BURST_WORDS - 1);
    localparam logic [SW-1:0] LAST_SLOT  = SW'(NUM_SLOTS - 1);
    localparam logic [31:0]   SLOT_BYTES = 32'(4 * BURST_WORDS);
    localparam logic [22:0]   BTT        = 23'(4 * BURST_WORDS);
    localparam logic [3:0]    MAX_OUT    = 4'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t        state, state_next;
    logic [SW-1:0] slot;
    logic [3:0]    tag;
    logic [3:0]    exp_tag;
    logic [CW-1:0] word_cnt;
    logic          in_data, last_word;
    logic          start, cmd_hs, data_hs, sts_hs, sts_err;
    logic [31:0]   saddr;

    // Gate on registered outstanding so status never reaches cmd_tvalid
    // combinationally.
    assign start     = enable && (outstanding < MAX_OUT);
    assign cmd_hs    = s_axis_s2mm_cmd_tvalid && s_axis_s2mm_cmd_tready;
    assign data_hs   = s_axis_s2mm_tvalid && s_axis_s2mm_tready;
    assign sts_hs    = m_axis_s2mm_sts_tvalid && m_axis_s2mm_sts_tready;
    assign last_word = (word_cnt == LAST_WORD);
    assign saddr     = BASE_ADDR + 32'(slot) * SLOT_BYTES;

    assign sts_err = !m_axis_s2mm_sts_tdata[7] || (m_axis_s2mm_sts_tdata[6:4] != 3'b000) ||
                     (m_axis_s2mm_sts_tdata[3:0] != exp_tag) || (outstanding == 4'd0);

    // State register
    always_ff @(posedge clk_in1 or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CMD;
            CMD:     if (cmd_hs) state_next = DATA;
            DATA:    if (data_hs && last_word) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs: zero-latency data pass-through while in DATA only
    always_comb begin
        in_data            = (state == DATA);
        s_axis_s2mm_tvalid = in_data && s_axis_tvalid;
        s_axis_tready      = in_data && s_axis_s2mm_tready;
        s_axis_s2mm_tlast  = in_data && last_word;
        s_axis_s2mm_tdata  = s_axis_tdata;
        s_axis_s2mm_tkeep  = 4'hF;
    end

    // Command is latched on the IDLE->CMD transition and held until accepted.
    always_ff @(posedge clk_in1 or negedge aresetn) begin
        if (!aresetn) begin
            s_axis_s2mm_cmd_tdata  <= '0;
            s_axis_s2mm_cmd_tvalid <= 1'b0;
        end else if (state == IDLE && start) begin
            s_axis_s2mm_cmd_tdata  <= {4'h0, tag, saddr, 1'b0, 1'b1, 6'h00, 1'b1, BTT};
            s_axis_s2mm_cmd_tvalid <= 1'b1;
        end else if (cmd_hs) begin
            s_axis_s2mm_cmd_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk_in1 or negedge aresetn) begin
        if (!aresetn) begin
            slot <= '0;
            tag  <= 4'd0;
        end else if (cmd_hs) begin
            slot <= (slot == LAST_SLOT) ? '0 : slot + 1'b1;
            tag  <= tag + 4'd1;
        end
    end

    always_ff @(posedge clk_in1 or negedge aresetn) begin
        if (!aresetn)     word_cnt <= '0;
        else if (data_hs) word_cnt <= last_word ? '0 : word_cnt + 1'b1;
    end

    // Status side
    always_ff @(posedge clk_in1 or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_s2mm_sts_tready <= 1'b0;
            exp_tag                <= 4'd0;
            burst_count            <= '0;
            err_count              <= '0;
        end else begin
            m_axis_s2mm_sts_tready <= 1'b1;
            if (sts_hs) begin
                exp_tag <= exp_tag + 4'd1;
                if (sts_err) begin
                    if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                end else begin
                    burst_count <= burst_count + 32'd1;
                end
            end
        end
    end

    // A status with nothing outstanding must not underflow the counter.
    always_ff @(posedge clk_in1 or negedge aresetn) begin
        if (!aresetn) begin
            outstanding <= 4'd0;
        end else begin
            case ({cmd_hs, sts_hs && (outstanding != 4'd0)})
                2'b10:   outstanding <= outstanding + 4'd1;
                2'b01:   outstanding <= outstanding - 4'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end
endmodule

// File: tb/tb_datamover_s2mm_framer.sv
module tb_datamover_s2mm_framer;
    localparam int BW = 128;
    localparam int NS = 16;
    localparam int MO = 2;
    localparam logic [31:0] BASE = 32'hC000_0000;

    logic        clk_in1 = 1'b0;
    logic        aresetn = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [71:0] s_axis_s2mm_cmd_tdata;
    logic        s_axis_s2mm_cmd_tvalid;
    logic        s_axis_s2mm_cmd_tready = 1'b0;
    logic [31:0] s_axis_s2mm_tdata;
    logic [3:0]  s_axis_s2mm_tkeep;
    logic        s_axis_s2mm_tlast;
    logic        s_axis_s2mm_tvalid;
    logic        s_axis_s2mm_tready = 1'b0;
    logic [7:0]  m_axis_s2mm_sts_tdata = '0;
    logic        m_axis_s2mm_sts_tvalid = 1'b0;
    logic        m_axis_s2mm_sts_tready;
    logic [31:0] burst_count;
    logic [15:0] err_count;
    logic [3:0]  outstanding;

    always #5 clk_in1 = ~clk_in1;

    datamover_s2mm_framer #(
        .BURST_WORDS(BW), .BASE_ADDR(BASE), .NUM_SLOTS(NS), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk_in1(clk_in1), .aresetn(aresetn), .enable(enable),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_s2mm_cmd_tdata(s_axis_s2mm_cmd_tdata), .s_axis_s2mm_cmd_tvalid(s_axis_s2mm_cmd_tvalid),
        .s_axis_s2mm_cmd_tready(s_axis_s2mm_cmd_tready),
        .s_axis_s2mm_tdata(s_axis_s2mm_tdata), .s_axis_s2mm_tkeep(s_axis_s2mm_tkeep),
        .s_axis_s2mm_tlast(s_axis_s2mm_tlast), .s_axis_s2mm_tvalid(s_axis_s2mm_tvalid),
        .s_axis_s2mm_tready(s_axis_s2mm_tready),
        .m_axis_s2mm_sts_tdata(m_axis_s2mm_sts_tdata), .m_axis_s2mm_sts_tvalid(m_axis_s2mm_sts_tvalid),
        .m_axis_s2mm_sts_tready(m_axis_s2mm_sts_tready),
        .burst_count(burst_count), .err_count(err_count), .outstanding(outstanding)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: transaction-level counts since the last reset.
    int m_cmds, m_beat, m_out, m_ok, m_err, m_exp_tag, src_cnt, cyc, last_tlast_cyc, stall_left;
    bit src_valid, auto_sts, sts_pend, bp, cmd_stall_mode, gap_chk;
    logic [7:0]  sts_data;
    logic        prev_dv, prev_dr, prev_cv, prev_cr;
    logic [31:0] prev_d;
    logic [71:0] prev_c;
    logic [71:0] cmd_log[$];
    logic [31:0] tlast_log[$];

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] mk_cmd(input logic [3:0] tag, input logic [31:0] saddr);
        return {4'h0, tag, saddr, 1'b0, 1'b1, 6'h00, 1'b1, 23'(4 * BW)};
    endfunction

    // n-th command after reset: slot n mod NS, tag n mod 16
    function automatic logic [71:0] exp_cmd(input int n);
        return mk_cmd(4'(n % 16), BASE + 32'((n % NS) * 4 * BW));
    endfunction

    task automatic do_reset();
        aresetn = 1'b0;
        #1;
        chk("rst_cmd_tvalid", s_axis_s2mm_cmd_tvalid, 0);
        chk("rst_cmd_tdata", s_axis_s2mm_cmd_tdata, 0);
        chk("rst_d_tvalid", s_axis_s2mm_tvalid, 0);
        chk("rst_s_tready", s_axis_tready, 0);
        chk("rst_sts_tready", m_axis_s2mm_sts_tready, 0);
        chk("rst_burst_count", burst_count, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_outstanding", outstanding, 0);
        enable = 0; s_axis_tvalid = 0; s_axis_tdata = 0; s_axis_s2mm_cmd_tready = 0;
        s_axis_s2mm_tready = 0; m_axis_s2mm_sts_tvalid = 0; m_axis_s2mm_sts_tdata = 0;
        m_cmds = 0; m_beat = 0; m_out = 0; m_ok = 0; m_err = 0; m_exp_tag = 0; src_cnt = 0;
        last_tlast_cyc = -1; stall_left = 0; src_valid = 0; sts_pend = 0;
        prev_dv = 0; prev_dr = 0; prev_cv = 0; prev_cr = 0; prev_d = 0; prev_c = 0;
        cmd_log.delete(); tlast_log.delete();
        repeat (3) @(negedge clk_in1);
        aresetn = 1'b1;
        #1;
        chk("rst_rel_sts_tready", m_axis_s2mm_sts_tready, 0);
        @(negedge clk_in1);
    endtask

    // One clock: drive at negedge, sample 1 time unit later, update model at posedge.
    task automatic cycle();
        bit chs, dhs, shs, srchs, e;
        if (!src_valid) src_valid = bp ? ($urandom_range(3) != 0) : 1'b1;
        s_axis_tvalid = src_valid;
        s_axis_tdata  = 32'(src_cnt);
        s_axis_s2mm_tready = bp ? 1'($urandom_range(1)) : 1'b1;
        if (cmd_stall_mode && s_axis_s2mm_cmd_tvalid && !prev_cv) stall_left = 5;
        s_axis_s2mm_cmd_tready = (stall_left > 0) ? 1'b0 : 1'b1;
        if (stall_left > 0) stall_left--;
        if (auto_sts && !sts_pend && m_out > 0 && $urandom_range(1) == 1) begin
            sts_pend = 1; sts_data = {4'h8, 4'(m_exp_tag)};
        end
        m_axis_s2mm_sts_tvalid = sts_pend;
        m_axis_s2mm_sts_tdata  = sts_data;
        #1;
        chk("outstanding", outstanding, m_out);
        chk("burst_count", burst_count, m_ok);
        chk("err_count", err_count, m_err);
        chk("sts_tready", m_axis_s2mm_sts_tready, 1);
        if (prev_dv && !prev_dr) begin
            chk("data_hold_valid", s_axis_s2mm_tvalid, 1);
            chk("data_hold_tdata", s_axis_s2mm_tdata, prev_d);
        end
        if (prev_cv && !prev_cr) begin
            chk("cmd_hold_valid", s_axis_s2mm_cmd_tvalid, 1);
            chk("cmd_hold_tdata", s_axis_s2mm_cmd_tdata, prev_c);
        end
        if (s_axis_s2mm_cmd_tvalid) chk("cmd_throttle", m_out < MO, 1);
        if (m_beat == m_cmds * BW) chk("no_burst_tready", s_axis_tready, 0);
        chs   = s_axis_s2mm_cmd_tvalid && s_axis_s2mm_cmd_tready;
        dhs   = s_axis_s2mm_tvalid && s_axis_s2mm_tready;
        shs   = m_axis_s2mm_sts_tvalid && m_axis_s2mm_sts_tready;
        srchs = s_axis_tvalid && s_axis_tready;
        chk("src_vs_dst_xfer", srchs, dhs);
        if (chs) begin
            chk("cmd_tdata", s_axis_s2mm_cmd_tdata, exp_cmd(m_cmds));
            chk("cmd_after_burst", m_beat == m_cmds * BW, 1);
            if (gap_chk && last_tlast_cyc >= 0) chk("b2b_gap", cyc - last_tlast_cyc, 2);
            cmd_log.push_back(s_axis_s2mm_cmd_tdata);
        end
        if (dhs) begin
            chk("tdata", s_axis_s2mm_tdata, 32'(m_beat));
            chk("tlast", s_axis_s2mm_tlast, (m_beat % BW) == BW - 1);
            chk("tkeep", s_axis_s2mm_tkeep, 4'hF);
            chk("in_burst", m_beat < m_cmds * BW, 1);
            if (s_axis_s2mm_tlast) begin
                tlast_log.push_back(s_axis_s2mm_tdata);
                last_tlast_cyc = cyc;
            end
        end
        e = 0;
        if (shs) e = !sts_data[7] || (sts_data[6:4] != 3'b000) ||
                     (sts_data[3:0] != 4'(m_exp_tag)) || (m_out == 0);
        prev_dv = s_axis_s2mm_tvalid; prev_dr = s_axis_s2mm_tready; prev_d = s_axis_s2mm_tdata;
        prev_cv = s_axis_s2mm_cmd_tvalid; prev_cr = s_axis_s2mm_cmd_tready; prev_c = s_axis_s2mm_cmd_tdata;
        @(posedge clk_in1);
        m_out = m_out + (chs ? 1 : 0) - ((shs && m_out > 0) ? 1 : 0);
        if (chs) m_cmds++;
        if (dhs) m_beat++;
        if (srchs) begin src_cnt++; src_valid = 0; end
        if (shs) begin
            if (e) m_err = (m_err == 65535) ? 65535 : m_err + 1;
            else   m_ok++;
            m_exp_tag = (m_exp_tag + 1) % 16;
            sts_pend = 0;
        end
        cyc++;
        @(negedge clk_in1);
    endtask

    initial begin
        int c0, b0;
        cyc = 0; auto_sts = 0; bp = 0; cmd_stall_mode = 0; gap_chk = 0; sts_data = 0;
        do_reset();

        // Status errors with nothing outstanding
        sts_pend = 1; sts_data = 8'hC0; cycle(); cycle();
        chk("sts_slverr", err_count, 1);
        sts_pend = 1; sts_data = 8'h81; cycle(); cycle();
        chk("sts_tag", err_count, 2);
        sts_pend = 1; sts_data = 8'h80; cycle(); cycle();
        chk("sts_none_out", err_count, 3);
        chk("sts_burst_count", burst_count, 0);
        chk("sts_outstanding", outstanding, 0);

        // Streaming, all ready, ring wrap
        do_reset();
        enable = 1; auto_sts = 1; gap_chk = 1;
        for (int i = 0; i < 6000 && m_cmds < 17; i++) cycle();
        chk("p1_cmds", m_cmds, 17);
        enable = 0;
        chk("cmd1", cmd_log[0], mk_cmd(4'h0, 32'hC000_0000));
        chk("cmd2", cmd_log[1], mk_cmd(4'h1, 32'hC000_0200));
        chk("cmd17_wrap", cmd_log[16], mk_cmd(4'h0, 32'hC000_0000));
        chk("tlast_word0", tlast_log[0], 127);
        chk("tlast_word1", tlast_log[1], 255);
        for (int i = 0; i < 1000 && !(m_beat == m_cmds * BW && m_out == 0); i++) cycle();
        chk("p1_drained", m_beat == m_cmds * BW && m_out == 0, 1);
        chk("p1_burst_count", burst_count, 17);
        gap_chk = 0;

        // Throttle: no status returned
        auto_sts = 0; enable = 1; c0 = m_cmds;
        repeat (400) cycle();
        chk("thr_cmds", m_cmds - c0, 2);
        chk("thr_out2", outstanding, 2);
        chk("thr_tready", s_axis_tready, 0);
        chk("thr_cmd_valid", s_axis_s2mm_cmd_tvalid, 0);
        sts_pend = 1; sts_data = {4'h8, 4'(m_exp_tag)}; cycle();
        chk("thr_out1", outstanding, 1);
        for (int i = 0; i < 20 && m_cmds < c0 + 3; i++) cycle();
        chk("thr_cmd3", m_cmds - c0, 3);
        chk("thr_out2_again", outstanding, 2);
        enable = 0; auto_sts = 1;
        for (int i = 0; i < 1000 && !(m_beat == m_cmds * BW && m_out == 0); i++) cycle();
        chk("thr_drained", m_beat == m_cmds * BW && m_out == 0, 1);

        // Random backpressure and command stalls
        bp = 1; cmd_stall_mode = 1; enable = 1; c0 = m_cmds; b0 = m_beat;
        for (int i = 0; i < 8000 && m_cmds < c0 + 4; i++) cycle();
        enable = 0;
        for (int i = 0; i < 4000 && !(m_beat == m_cmds * BW && m_out == 0); i++) cycle();
        chk("bp_cmds", m_cmds - c0, 4);
        chk("bp_words", m_beat - b0, 4 * BW);
        bp = 0; cmd_stall_mode = 0;

        // Reset in the middle of a burst
        enable = 1;
        for (int i = 0; i < 1000 && !(m_beat < m_cmds * BW && m_beat % BW == 60); i++) cycle();
        chk("mid_reached", m_beat % BW, 60);
        do_reset();
        enable = 1; auto_sts = 1;
        for (int i = 0; i < 50 && m_cmds < 1; i++) cycle();
        chk("post_rst_cmd", cmd_log[0], mk_cmd(4'h0, 32'hC000_0000));
        enable = 0;
        repeat (5) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
